// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates instruction-fetch and data accesses onto one shared
//            single-port RAM, with a per-access timeout and a sticky bus_err.
//            Define MEM_ARB_RR_EN for round-robin priority (default: MEM wins).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ack,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  ram_ack,
    output logic                  if_stall,
    output logic                  mem_stall,
    output logic                  bus_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GNT_IF  = 2'd1;
    localparam logic [1:0] S_GNT_MEM = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       r_owner_mem;
    logic [7:0] r_tcnt;
    logic       w_pick_mem;
    logic       w_in_gnt;
    logic       w_timeout;
    logic       w_start;

`ifdef MEM_ARB_RR_EN
    // r_prio = 1 favours IF; only consulted when both ports request together.
    logic r_prio;
    assign w_pick_mem = mem_req & (~if_req | ~r_prio);
`else
    assign w_pick_mem = mem_req;
`endif

    assign w_in_gnt  = (r_state == S_GNT_IF) || (r_state == S_GNT_MEM);
    assign w_timeout = w_in_gnt & ~ram_ack & (r_tcnt == C_TMO_LAST);
    assign w_start   = (r_state == S_IDLE) && (w_next != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick_mem) begin
                    w_next = S_GNT_MEM;
                end else if (if_req) begin
                    w_next = S_GNT_IF;
                end
            end
            S_GNT_IF, S_GNT_MEM: begin
                if (ram_ack || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        ram_cs  = w_in_gnt;
        if_ack  = (r_state == S_DONE) & ~r_owner_mem;
        mem_ack = (r_state == S_DONE) &  r_owner_mem;
    end

    assign if_stall  = if_req  & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;

    // Request capture, read-data latching and timeout tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= '0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
            bus_err     <= 1'b0;
            r_tcnt      <= '0;
            r_owner_mem <= 1'b0;
        end else begin
            if (w_start) begin
                r_owner_mem <= w_pick_mem;
                r_tcnt      <= '0;
                ram_we      <= w_pick_mem & mem_we;
                ram_addr    <= w_pick_mem ? mem_addr  : if_addr;
                ram_din     <= w_pick_mem ? mem_wdata : '0;
            end
            if (w_in_gnt) begin
                if (ram_ack) begin
                    if (r_owner_mem) begin
                        mem_rdata <= ram_dout;
                    end else begin
                        if_rdata <= ram_dout;
                    end
                end else begin
                    r_tcnt <= r_tcnt + 8'd1;
                end
                if (w_timeout) begin
                    bus_err <= 1'b1;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_prio <= r_owner_mem;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a behavioural RAM and a
//            transaction-level model of grant order, latency and read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_ack;
    logic          if_stall;
    logic          mem_stall;
    logic          bus_err;

    int       dly = -1;
    bit       stray = 1'b0;
    bit       dforce = 1'b0;
    logic [31:0] dval = '0;
    int       cs_cycles = 0;
    int       checks = 0;
    int       errors = 0;
    bit       rr = 1'b0;
    logic [31:0] exp_if_rd = '0;
    logic [31:0] exp_mem_rd = '0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_ack(ram_ack),
        .if_stall(if_stall), .mem_stall(mem_stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dout_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // RAM model: answers dly cycles after chip-select rises (never if dly < 0)
    assign ram_dout = dforce ? dval : dout_of(ram_addr);
    assign ram_ack  = stray | (ram_cs & (dly >= 0) & (cs_cycles == dly));
    always @(posedge clk) cs_cycles <= ram_cs ? cs_cycles + 1 : 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({ram_cs, ram_we, if_ack, mem_ack, bus_err, if_stall, mem_stall} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {ram_cs, ram_we, if_ack, mem_ack, bus_err, if_stall, mem_stall});
        end
        checks++;
        if ({ram_addr, ram_din, if_rdata, mem_rdata} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h expected all zero",
                     ram_addr, ram_din, if_rdata, mem_rdata);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (ram_cs !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ram_cs got %b expected 0", ram_cs);
        end
        rr = 1'b0;
        exp_if_rd = '0;
        exp_mem_rd = '0;
    endtask

    // Drive one or two requests, hold them until acked, check against the model
    task automatic run_pair(input bit use_if, input bit use_mem, input int d,
                            input logic [31:0] ia, input logic [31:0] ma,
                            input logic [31:0] md, input bit mwe);
        int          q[$];
        logic [31:0] a_of[2];
        logic        we_of[2];
        logic [31:0] din_of[2];
        int          t_exp;
        int          cs_cnt;
        int          t;
        int          port;
        int          first;
        a_of[0] = ia;  we_of[0] = 1'b0; din_of[0] = '0;
        a_of[1] = ma;  we_of[1] = mwe;  din_of[1] = md;
        dly = d;
        if_req = use_if;   if_addr = ia;
        mem_req = use_mem; mem_we = mwe; mem_addr = ma; mem_wdata = md;
        if (use_if && use_mem) begin
`ifdef MEM_ARB_RR_EN
            first = rr ? 0 : 1;
`else
            first = 1;
`endif
            q.push_back(first);
            q.push_back(1 - first);
        end else if (use_mem) begin
            q.push_back(1);
        end else if (use_if) begin
            q.push_back(0);
        end
        t_exp = d + 2;
        cs_cnt = 0;
        t = 0;
        while (q.size() > 0 && t < 60) begin
            tick();
            t++;
            if (ram_cs) begin
                cs_cnt++;
                checks++;
                if (ram_addr !== a_of[q[0]] || ram_we !== we_of[q[0]] || ram_din !== din_of[q[0]]) begin
                    errors++;
                    $display("FAIL ram_req: got addr=%h we=%b din=%h expected addr=%h we=%b din=%h",
                             ram_addr, ram_we, ram_din, a_of[q[0]], we_of[q[0]], din_of[q[0]]);
                end
            end
            checks++;
            if (if_stall !== (if_req & ~if_ack) || mem_stall !== (mem_req & ~mem_ack)) begin
                errors++;
                $display("FAIL stall: got if=%b mem=%b expected if=%b mem=%b", if_stall, mem_stall,
                         if_req & ~if_ack, mem_req & ~mem_ack);
            end
            if (if_ack || mem_ack) begin
                port = mem_ack ? 1 : 0;
                checks++;
                if ((if_ack && mem_ack) || port != q[0]) begin
                    errors++;
                    $display("FAIL ack_order: got if_ack=%b mem_ack=%b expected port %0d",
                             if_ack, mem_ack, q[0]);
                end
                checks++;
                if (t != t_exp) begin
                    errors++;
                    $display("FAIL ack_time: got cycle %0d expected %0d", t, t_exp);
                end
                checks++;
                if (cs_cnt != d + 1) begin
                    errors++;
                    $display("FAIL cs_len: got %0d expected %0d", cs_cnt, d + 1);
                end
                if (port == 1) exp_mem_rd = dout_of(ma);
                else           exp_if_rd  = dout_of(ia);
                checks++;
                if (if_rdata !== exp_if_rd || mem_rdata !== exp_mem_rd) begin
                    errors++;
                    $display("FAIL rdata: got if=%h mem=%h expected if=%h mem=%h",
                             if_rdata, mem_rdata, exp_if_rd, exp_mem_rd);
                end
                if (port == 1) mem_req = 1'b0;
                else           if_req = 1'b0;
                rr = (port == 1);
                void'(q.pop_front());
                cs_cnt = 0;
                t_exp = t + d + 3;
            end
        end
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL ack_wait: %0d accesses still pending expected 0", q.size());
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        tick();
        checks++;
        if (ram_cs !== 1'b0 || if_ack !== 1'b0 || mem_ack !== 1'b0) begin
            errors++;
            $display("FAIL post_idle: got cs=%b if_ack=%b mem_ack=%b expected 0 0 0",
                     ram_cs, if_ack, mem_ack);
        end
    endtask

    task automatic test_if_zero_wait();
        dforce = 1'b1;
        dval = 32'h1234ABCD;
        dly = 0;
        if_req = 1'b1;
        if_addr = 32'h100;
        tick();
        checks++;
        if (ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h100 || if_ack !== 1'b0 || if_stall !== 1'b1) begin
            errors++;
            $display("FAIL zw_grant: got cs=%b we=%b addr=%h ack=%b stall=%b expected 1 0 00000100 0 1",
                     ram_cs, ram_we, ram_addr, if_ack, if_stall);
        end
        tick();
        checks++;
        if (if_ack !== 1'b1 || if_rdata !== 32'h1234ABCD || if_stall !== 1'b0) begin
            errors++;
            $display("FAIL zw_ack: got ack=%b rdata=%h stall=%b expected 1 1234abcd 0",
                     if_ack, if_rdata, if_stall);
        end
        exp_if_rd = 32'h1234ABCD;
        rr = 1'b0;
        if_req = 1'b0;
        tick();
        checks++;
        if (if_ack !== 1'b0 || ram_cs !== 1'b0) begin
            errors++;
            $display("FAIL zw_after: got ack=%b cs=%b expected 0 0", if_ack, ram_cs);
        end
        dforce = 1'b0;
    endtask

    task automatic test_simultaneous();
        run_pair(1'b1, 1'b1, 0, 32'h200, 32'h40, 32'hDEADBEEF, 1'b1);
    endtask

    task automatic test_delay3();
        run_pair(1'b0, 1'b1, 3, 32'h0, 32'h80, 32'hCAFEF00D, 1'b1);
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL delay3_err: bus_err got %b expected 0", bus_err);
        end
    endtask

    task automatic test_stray_ack();
        stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_ack !== 1'b0 || mem_ack !== 1'b0 || ram_cs !== 1'b0 ||
                if_rdata !== exp_if_rd || mem_rdata !== exp_mem_rd) begin
                errors++;
                $display("FAIL stray_ack: got if_ack=%b mem_ack=%b cs=%b if=%h mem=%h expected 0 0 0 %h %h",
                         if_ack, mem_ack, ram_cs, if_rdata, mem_rdata, exp_if_rd, exp_mem_rd);
            end
        end
        stray = 1'b0;
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 20; i++) begin
            k = $urandom_range(0, 2);
            run_pair(k != 1, k != 0, $urandom_range(0, 2), $urandom & 32'hFFFFFFFC,
                     $urandom & 32'hFFFFFFFC, $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        run_pair(1'b1, 1'b1, 1, 32'h300, 32'h304, 32'h11112222, 1'b0);
        run_pair(1'b1, 1'b1, 0, 32'h308, 32'h30C, 32'h33334444, 1'b1);
    endtask

    task automatic test_timeout();
        int  cs_cnt;
        bit  got;
        dly = -1;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_addr = 32'h500;
        cs_cnt = 0;
        got = 1'b0;
        for (int t = 1; t <= 20 && !got; t++) begin
            tick();
            if (ram_cs) cs_cnt++;
            if (mem_ack) begin
                got = 1'b1;
                checks++;
                if (t != TMO + 1 || cs_cnt != TMO || bus_err !== 1'b1 || mem_rdata !== exp_mem_rd) begin
                    errors++;
                    $display("FAIL timeout: got t=%0d cs=%0d err=%b rdata=%h expected %0d %0d 1 %h",
                             t, cs_cnt, bus_err, mem_rdata, TMO + 1, TMO, exp_mem_rd);
                end
            end else begin
                checks++;
                if (bus_err !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early: bus_err got %b expected 0 at cycle %0d", bus_err, t);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout_ack: mem_ack got none expected a pulse");
        end
        mem_req = 1'b0;
        rr = 1'b1;
        repeat (3) tick();
        run_pair(1'b1, 1'b0, 0, 32'h600, 32'h0, 32'h0, 1'b0);
        checks++;
        if (bus_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: bus_err got %b expected 1", bus_err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr = 1'b0;
        exp_if_rd = '0;
        exp_mem_rd = '0;
        tick();
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: bus_err got %b expected 0", bus_err);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        dly = -1;
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = 32'h700;
        mem_wdata = 32'h0BADC0DE;
        tick();
        tick();
        checks++;
        if (ram_cs !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_gnt: ram_cs got %b expected 1", ram_cs);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (ram_cs !== 1'b0 || mem_ack !== 1'b0 || ram_addr !== '0) begin
            errors++;
            $display("FAIL rstmid_cs: got cs=%b ack=%b addr=%h expected 0 0 00000000",
                     ram_cs, mem_ack, ram_addr);
        end
        rst = 1'b0;
        mem_req = 1'b0;
        rr = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (mem_ack) seen = 1'b1;
        end
        checks++;
        if (seen || mem_rdata !== '0) begin
            errors++;
            $display("FAIL rstmid_ack: got ack_seen=%b rdata=%h expected 0 00000000", seen, mem_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_if_zero_wait();
        test_simultaneous();
        test_delay3();
        test_stray_ack();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of all address ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of all data ports.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum number of cycles to wait for ram_ack; legal range 1-255.
REQ-004 SHALL have port clk  input  1  main clock; one clock domain, all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port if_req  input  1  instruction-fetch read request.
REQ-007 SHALL have port if_addr  input  ADDR_WIDTH  fetch address.
REQ-008 SHALL have port if_rdata  output  DATA_WIDTH  fetched word.
REQ-009 SHALL have port if_ack  output  1  one-cycle fetch-complete pulse.
REQ-010 SHALL have port mem_req  input  1  data-access request from the MEM stage.
REQ-011 SHALL have port mem_we  input  1  data-access write enable; 0 = read.
REQ-012 SHALL have port mem_addr  input  ADDR_WIDTH  data address.
REQ-013 SHALL have port mem_wdata  input  DATA_WIDTH  store data.
REQ-014 SHALL have port mem_rdata  output  DATA_WIDTH  load data.
REQ-015 SHALL have port mem_ack  output  1  one-cycle data-complete pulse.
REQ-016 SHALL have ports ram_cs (output, 1), ram_we (output, 1), ram_addr (output, ADDR_WIDTH) and ram_din (output, DATA_WIDTH), forming the shared single-port memory request.
REQ-017 SHALL have ports ram_dout (input, DATA_WIDTH) and ram_ack (input, 1), forming the memory response.
REQ-018 SHALL have ports if_stall and mem_stall (output, 1 each), stall requests to the pipeline controller.
REQ-019 SHALL have port bus_err  output  1  sticky memory-timeout flag.

Function
REQ-020 SHALL implement an FSM with states IDLE, GNT_IF, GNT_MEM, DONE.
REQ-021 In IDLE, with mem_req=1, the FSM SHALL go to GNT_MEM; otherwise, with if_req=1, it SHALL go to GNT_IF; otherwise it SHALL stay in IDLE.
REQ-022 On the IDLE->GNT_x edge, the block SHALL register the requester's address, we and wdata onto the ram_* outputs. For IF, ram_we=0 and ram_din=0.
REQ-023 ram_cs SHALL be 1 exactly while in GNT_IF or GNT_MEM, and 0 in all other states.
REQ-024 In GNT_x with ram_ack=1, the block SHALL latch ram_dout into that requester's rdata register and go to DONE.
REQ-025 In DONE, the block SHALL assert the granted requester's ack for exactly one cycle and then go to IDLE. Requests SHALL NOT be sampled in DONE.
REQ-026 Latency: request seen at edge N gives ram_cs=1 in cycle N+1. If ram_ack arrives in cycle M, ack=1 in cycle M+1. The minimum request-to-ack time is 2 cycles.
REQ-027 Each requester SHALL hold req, addr, we and wdata stable until its ack, and deassert or update them at the edge that ends the ack cycle.
REQ-028 if_rdata and mem_rdata SHALL hold their value until the next completed access on the same port.
REQ-029 if_stall SHALL equal if_req & ~if_ack, and mem_stall SHALL equal mem_req & ~mem_ack; both are combinational.
REQ-030 If a requester drops req mid-access, the access SHALL complete and ack SHALL still pulse. The requester ignores it.
REQ-031 A timeout counter SHALL reset to 0 on entry to GNT_x and increment each GNT_x cycle without ram_ack.
REQ-032 When the timeout counter reaches TIMEOUT, the block SHALL set bus_err=1, go to DONE, pulse ack, and leave rdata unchanged.
REQ-033 bus_err SHALL clear only on rst.
REQ-034 ram_ack outside GNT_x SHALL be ignored.

Reset
REQ-035 rst SHALL force, at the next edge: state IDLE, ram_cs=0, ram_we=0, ram_addr=0, ram_din=0, if_rdata=0, mem_rdata=0, if_ack=0, mem_ack=0, bus_err=0, timeout counter=0, and the RR priority bit=0 (MEM first).
REQ-036 A reset asserted mid-access SHALL abandon the access, generate no ack, and deassert ram_cs from the next cycle.
REQ-037 After rst, the stall outputs SHALL follow REQ-029 directly.

Configuration
REQ-038 The macro MEM_ARB_RR_EN SHALL select between fixed and round-robin priority.
REQ-039 With MEM_ARB_RR_EN undefined, priority SHALL be fixed: MEM wins every simultaneous request.
REQ-040 With MEM_ARB_RR_EN defined, a priority bit SHALL flip to favour the other port after each completed grant, and only a simultaneous request SHALL use it. A lone request SHALL always be granted.

Verification
REQ-041 Zero-wait RAM (ram_ack=1 whenever ram_cs=1), if_req=1 with if_addr=0x100 and ram_dout=0x1234ABCD: if_ack SHALL pulse 2 cycles after the request, with if_rdata=0x1234ABCD and ram_we=0.
REQ-042 if_req and mem_req both rise in the same cycle, with mem_we=1, mem_addr=0x40 and mem_wdata=0xDEADBEEF: the MEM grant SHALL come first (ram_we=1, ram_din=0xDEADBEEF), then IF, with if_stall=1 throughout.
REQ-043 RAM delays ram_ack by 3 cycles: ram_cs SHALL stay high for 4 cycles with ram_addr stable, and ack SHALL follow one cycle later.
REQ-044 TIMEOUT=4 and no ram_ack: bus_err SHALL rise after 4 GNT cycles, ack SHALL pulse, and bus_err SHALL stay 1 until rst.
REQ-045 rst asserted in the second GNT_MEM cycle: the next cycle SHALL show ram_cs=0 and mem_ack SHALL never pulse.
REQ-046 With MEM_ARB_RR_EN defined and both requests held for 4 accesses: the grant order SHALL be MEM, IF, MEM, IF.
